// File: rtl/i2c_cfg_seq.sv
// i2c_cfg_seq: walks a command table of i2c register writes, mux selects
// and delays, retrying NACKed transfers and flagging exhausted retries.
module i2c_cfg_seq #(
  parameter int NBYTES    = 3,
  parameter int TBL_AW    = 6,
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 1000
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o,
  output logic [TBL_AW-1:0]          err_idx_o,
  output logic [TBL_AW-1:0]          tbl_addr_o,
  input  logic [31:0]                tbl_data_i,
  output logic                       i2c_send_o,
  output logic [$clog2(NBYTES)-1:0]  i2c_nbytes_o,
  output logic [NBYTES*8-1:0]        i2c_data_o,
  input  logic                       i2c_ready_i,
  input  logic                       i2c_done_i,
  input  logic [NBYTES-1:0]          i2c_status_i
);

  localparam int DW  = NBYTES * 8;
  localparam int NBW = $clog2(NBYTES);
  localparam int RW  = $clog2(MAX_RETRY + 2);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_ISSUE   = 4'd3;
  localparam logic [3:0] S_WAIT    = 4'd4;
  localparam logic [3:0] S_CHECK   = 4'd5;
  localparam logic [3:0] S_BACKOFF = 4'd6;
  localparam logic [3:0] S_DELAY   = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]        state;
  logic [TBL_AW-1:0] idx;
  logic [RW-1:0]     retry;
  logic [23:0]       cnt;
  logic [NBYTES-1:0] need;
  logic              last;
  logic              pass;
  logic              unused_tbl;

  assign unused_tbl = ^tbl_data_i[29:24];

  assign busy_o     = (state != S_IDLE);
  assign done_o     = (state == S_DONE);
  assign tbl_addr_o = idx;
  assign last       = (idx == {TBL_AW{1'b1}});
  assign pass       = ((i2c_status_i & need) == need);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      idx          <= '0;
      retry        <= '0;
      cnt          <= '0;
      need         <= '0;
      error_o      <= 1'b0;
      err_idx_o    <= '0;
      i2c_send_o   <= 1'b0;
      i2c_nbytes_o <= '0;
      i2c_data_o   <= '0;
    end else begin
      i2c_send_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            state   <= S_FETCH;
            idx     <= '0;
            retry   <= '0;
            error_o <= 1'b0;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          unique case (tbl_data_i[31:30])
            2'b00: begin
              i2c_data_o   <= DW'({tbl_data_i[7:0], tbl_data_i[15:8],
                                   tbl_data_i[23:16]});
              i2c_nbytes_o <= NBW'(2);
              need         <= NBYTES'(7);
              state        <= S_ISSUE;
            end
            2'b01: begin
              i2c_data_o   <= DW'({8'h00, tbl_data_i[7:0],
                                   tbl_data_i[23:16]});
              i2c_nbytes_o <= NBW'(1);
              need         <= NBYTES'(3);
              state        <= S_ISSUE;
            end
            2'b10: begin
              cnt   <= tbl_data_i[23:0];
              state <= S_DELAY;
            end
            default: state <= S_DONE;
          endcase
        end
        S_ISSUE: begin
          if (i2c_ready_i) begin
            i2c_send_o <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i2c_done_i) state <= S_CHECK;
        end
        // status is final by the cycle after done
        S_CHECK: begin
          if (pass) begin
            retry <= '0;
            if (last) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + TBL_AW'(1);
              state <= S_FETCH;
            end
          end else if (retry < RW'(MAX_RETRY)) begin
            retry <= retry + RW'(1);
            cnt   <= 24'(RETRY_GAP - 1);
            state <= S_BACKOFF;
          end else begin
            error_o   <= 1'b1;
            err_idx_o <= idx;
            state     <= S_IDLE;
          end
        end
        S_BACKOFF: begin
          if (cnt == 24'd0) state <= S_ISSUE;
          else cnt <= cnt - 24'd1;
        end
        S_DELAY: begin
          if (cnt == 24'd0) begin
            if (last) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + TBL_AW'(1);
              state <= S_FETCH;
            end
          end else begin
            cnt <= cnt - 24'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// tb_i2c_cfg_seq: directed bench with a table ROM, an i2c master model
// and a scoreboard of expected send transactions.
module tb_i2c_cfg_seq;

  localparam int NBYTES    = 3;
  localparam int TBL_AW    = 6;
  localparam int MAX_RETRY = 3;
  localparam int RETRY_GAP = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, error;
  logic [5:0]  err_idx, tbl_addr;
  logic [31:0] tbl_data;
  logic        send;
  logic [1:0]  nbytes;
  logic [23:0] data;
  logic        ready, mdone;
  logic [2:0]  status;

  always #5 clk = ~clk;

  i2c_cfg_seq #(
    .NBYTES(NBYTES), .TBL_AW(TBL_AW),
    .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .busy_o(busy), .done_o(done), .error_o(error),
    .err_idx_o(err_idx), .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data),
    .i2c_send_o(send), .i2c_nbytes_o(nbytes), .i2c_data_o(data),
    .i2c_ready_i(ready), .i2c_done_i(mdone), .i2c_status_i(status)
  );

  logic [31:0] rom [64];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // i2c master model: fixed latency, NACK policy set by the stimulus
  logic       ready_en;
  logic       m_busy;
  int         m_cnt;
  int         nacked;
  int         nack_lim;
  logic [7:0] nack_addr, fail_addr, m_addr;

  assign ready = ready_en && !m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_cnt <= 0; mdone <= 1'b0;
      status <= '0; nacked <= 0; m_addr <= '0;
    end else begin
      mdone <= 1'b0;
      if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy <= 1'b0;
          mdone  <= 1'b1;
          if (fail_addr != 8'h00 && m_addr == fail_addr) begin
            status <= 3'b101;
          end else if (m_addr == nack_addr && nacked < nack_lim) begin
            status <= 3'b101;
            nacked <= nacked + 1;
          end else begin
            status <= 3'b111;
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (send) begin
        m_busy <= 1'b1;
        m_cnt  <= 20;
        m_addr <= data[7:0];
      end
    end
  end

  int          cyc = 0;
  int          n_send = 0, n_done = 0, n_mdone = 0, n_wide = 0;
  logic        prev_send = 1'b0;
  logic [23:0] obs_data [64];
  logic [1:0]  obs_nb   [64];
  int          obs_cyc  [64];
  int          mdone_cyc[64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_send <= send;
    if (send) begin
      if (prev_send) n_wide <= n_wide + 1;
      if (n_send < 64) begin
        obs_data[n_send] <= data;
        obs_nb[n_send]   <= nbytes;
        obs_cyc[n_send]  <= cyc;
      end
      n_send <= n_send + 1;
    end
    if (done) n_done <= n_done + 1;
    if (mdone) begin
      if (n_mdone < 64) mdone_cyc[n_mdone] <= cyc;
      n_mdone <= n_mdone + 1;
    end
  end

  int          vectors = 0;
  int          miscompares = 0;
  int          rd = 0;
  logic [25:0] expq[$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] wr(input logic [7:0] a,
                                     input logic [7:0] r,
                                     input logic [7:0] v);
    return {8'h00, a, r, v};
  endfunction

  function automatic logic [31:0] mx(input logic [7:0] a,
                                     input logic [7:0] v);
    return {8'h40, a, 8'h00, v};
  endfunction

  task automatic expw(input logic [7:0] a, input logic [7:0] r,
                      input logic [7:0] v);
    expq.push_back({2'd2, v, r, a});
  endtask

  task automatic expm(input logic [7:0] a, input logic [7:0] v);
    expq.push_back({2'd1, 8'h00, v, a});
  endtask

  task automatic pull(input string tag);
    logic [25:0] e;
    while (rd < n_send) begin
      if (expq.size() == 0) begin
        check({tag, "_unexpected_send"}, 64'(n_send - rd), 64'(0));
      end else begin
        e = expq.pop_front();
        check({tag, "_data"}, 64'(obs_data[rd]), 64'(e[23:0]));
        check({tag, "_nbytes"}, 64'(obs_nb[rd]), 64'(e[25:24]));
      end
      rd++;
    end
    check({tag, "_missing_sends"}, 64'(expq.size()), 64'(0));
    expq.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    check({tag, "_idle_timeout"}, 64'(busy), 64'(0));
  endtask

  initial begin
    int s0, d0, m0, t0, tr, k;
    rst_n = 1'b0; start = 1'b0; ready_en = 1'b1;
    nack_addr = 8'h00; fail_addr = 8'h00; nack_lim = 0;
    for (int i = 0; i < 64; i++) rom[i] = 32'hC000_0000;
    step(); step();

    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_err_idx", 64'(err_idx), 64'(0));
    check("rst_tbl_addr", 64'(tbl_addr), 64'(0));
    check("rst_send", 64'(send), 64'(0));
    check("rst_nbytes", 64'(nbytes), 64'(0));
    check("rst_data", 64'(data), 64'(0));
    rst_n = 1'b1;
    step();

    // basic write + muxsel, with a start during the DONE cycle
    rom[0] = wr(8'h72, 8'h41, 8'h10);
    rom[1] = mx(8'hE8, 8'h20);
    rom[2] = 32'hC000_0000;
    expw(8'h72, 8'h41, 8'h10);
    expm(8'hE8, 8'h20);
    s0 = n_send; d0 = n_done;
    pulse_start();
    t0 = cyc;
    k = 0;
    while (!done && k < 500) begin step(); k++; end
    check("t1_done_seen", 64'(done), 64'(1));
    pulse_start();
    check("t1_start_at_done_ignored", 64'(busy), 64'(0));
    step();
    pull("t1");
    check("t1_latency", 64'(obs_cyc[s0] - t0), 64'(3));
    check("t1_sends", 64'(n_send - s0), 64'(2));
    check("t1_done_count", 64'(n_done - d0), 64'(1));
    check("t1_error", 64'(error), 64'(0));

    // ready held low, start while busy
    rom[0] = wr(8'h33, 8'h01, 8'h02);
    rom[1] = 32'hC000_0000;
    expw(8'h33, 8'h01, 8'h02);
    ready_en = 1'b0;
    s0 = n_send;
    pulse_start();
    repeat (20) step();
    check("t2_no_send_not_ready", 64'(n_send - s0), 64'(0));
    pulse_start();
    tr = cyc;
    ready_en = 1'b1;
    wait_idle(300, "t2");
    pull("t2");
    check("t2_send_after_ready", 64'(obs_cyc[s0] > tr), 64'(1));

    // NACK twice on byte 1, then ACK
    rom[0] = wr(8'h72, 8'h41, 8'h10);
    rom[1] = mx(8'hE8, 8'h20);
    rom[2] = 32'hC000_0000;
    repeat (3) expw(8'h72, 8'h41, 8'h10);
    expm(8'hE8, 8'h20);
    nack_addr = 8'h72; nack_lim = 2;
    s0 = n_send; d0 = n_done;
    pulse_start();
    wait_idle(5000, "t3");
    pull("t3");
    check("t3_gap1", 64'(obs_cyc[s0+1] - obs_cyc[s0] >= RETRY_GAP), 64'(1));
    check("t3_gap2", 64'(obs_cyc[s0+2] - obs_cyc[s0+1] >= RETRY_GAP), 64'(1));
    check("t3_error", 64'(error), 64'(0));
    check("t3_done_count", 64'(n_done - d0), 64'(1));
    nack_addr = 8'h00;

    // entry 2 always NACKed
    rom[0] = wr(8'h72, 8'h41, 8'h10);
    rom[1] = wr(8'h50, 8'h0A, 8'h0B);
    rom[2] = wr(8'h5A, 8'h01, 8'h02);
    rom[3] = 32'hC000_0000;
    expw(8'h72, 8'h41, 8'h10);
    expw(8'h50, 8'h0A, 8'h0B);
    repeat (1 + MAX_RETRY) expw(8'h5A, 8'h01, 8'h02);
    fail_addr = 8'h5A;
    s0 = n_send; d0 = n_done;
    pulse_start();
    wait_idle(8000, "t4");
    pull("t4");
    check("t4_sends", 64'(n_send - s0), 64'(6));
    check("t4_error", 64'(error), 64'(1));
    check("t4_err_idx", 64'(err_idx), 64'(2));
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_no_done", 64'(n_done - d0), 64'(0));
    fail_addr = 8'h00;
    expw(8'h72, 8'h41, 8'h10);
    expw(8'h50, 8'h0A, 8'h0B);
    expw(8'h5A, 8'h01, 8'h02);
    pulse_start();
    check("t4_error_cleared", 64'(error), 64'(0));
    wait_idle(500, "t4b");
    pull("t4b");
    check("t4b_done_count", 64'(n_done - d0), 64'(1));

    // delay 500 and delay 0
    rom[0] = wr(8'h72, 8'h41, 8'h10);
    rom[1] = 32'h8000_01F4;
    rom[2] = wr(8'h44, 8'h05, 8'h06);
    rom[3] = 32'h8000_0000;
    rom[4] = wr(8'h46, 8'h07, 8'h08);
    rom[5] = 32'hC000_0000;
    expw(8'h72, 8'h41, 8'h10);
    expw(8'h44, 8'h05, 8'h06);
    expw(8'h46, 8'h07, 8'h08);
    s0 = n_send; m0 = n_mdone;
    pulse_start();
    wait_idle(2000, "t5");
    pull("t5");
    check("t5_delay500", 64'(obs_cyc[s0+1] - mdone_cyc[m0] >= 500), 64'(1));
    check("t5_delay0", 64'(obs_cyc[s0+2] - mdone_cyc[m0+1] <= 8), 64'(1));

    // async reset while waiting on entry 1
    rom[0] = wr(8'h72, 8'h41, 8'h10);
    rom[1] = wr(8'h50, 8'h0A, 8'h0B);
    rom[2] = 32'hC000_0000;
    expw(8'h72, 8'h41, 8'h10);
    expw(8'h50, 8'h0A, 8'h0B);
    s0 = n_send;
    pulse_start();
    k = 0;
    while (n_send - s0 < 2 && k < 500) begin step(); k++; end
    check("t6_reached_wait", 64'(n_send - s0), 64'(2));
    repeat (3) step();
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 64'(busy), 64'(0));
    check("t6_rst_tbl_addr", 64'(tbl_addr), 64'(0));
    check("t6_rst_data", 64'(data), 64'(0));
    check("t6_rst_nbytes", 64'(nbytes), 64'(0));
    check("t6_rst_send", 64'(send), 64'(0));
    check("t6_rst_done", 64'(done), 64'(0));
    step();
    rst_n = 1'b1;
    step();
    pull("t6");
    expw(8'h72, 8'h41, 8'h10);
    expw(8'h50, 8'h0A, 8'h0B);
    d0 = n_done;
    pulse_start();
    wait_idle(500, "t6b");
    pull("t6b");
    check("t6b_done_count", 64'(n_done - d0), 64'(1));
    check("send_width", 64'(n_wide), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
